seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_pkg.sv | 39 +++
 rtl/hex7seg.sv | 35 +++
 rtl/seg_scan.sv | 132 +++++++++++++
 tb/tb_seg_scan.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg_pkg;

  // Scanner slot phase: blanked guard interval, then digit drive.
  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  // Active-low segment glyphs, bit order {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] BLANK = 8'hFF;

  // All digit enables released (active-low).
  localparam logic [3:0] AN_OFF = 4'hF;

  // True when digit idx is a leading zero: idx > 0 and nibbles idx..3 all zero.
  function automatic logic lz_blank(input logic [15:0] val, input logic [1:0] idx);
    return (idx != 2'd0) && ((val >> {idx, 2'b00}) == 16'h0000);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment glyph decoder.
// Latency: purely combinational.
// Backpressure: none.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  // Table lookup of the glyph for one hex digit.
  always_comb begin
    o_seg = BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// 4-digit multiplexed 7-segment scanner with a one-deep pending word buffer.
// Latency: an/seg/frame_done registered, 1 cycle after state/index change; new word shown from the frame after the swap.
// Backpressure: in_ready low while a word is pending; it is swapped into the display at frame end.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_GUARD = DIV_W'(GUARD);

  logic [15:0]      r_disp;
  logic [15:0]      r_pend;
  logic             r_pend_full;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  scan_state_t      r_state;
  logic [3:0]       r_an;
  logic [7:0]       r_seg;
  logic             r_frame_done;

  logic             w_slot_end;
  logic             w_frame_end;
  logic [DIV_W-1:0] w_div_nxt;
  logic [1:0]       w_idx_nxt;
  logic             w_xfer;
  logic [3:0]       w_nib;
  logic [7:0]       w_glyph;
  scan_state_t      w_state_nxt;
  logic [3:0]       w_an_nxt;
  logic [7:0]       w_seg_nxt;

  assign in_ready    = !r_pend_full;
  assign w_xfer      = in_valid && !r_pend_full;
  assign w_slot_end  = (r_div == DIV_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 2'd3);
  assign w_div_nxt   = w_slot_end ? '0 : r_div + DIV_W'(1);
  assign w_idx_nxt   = w_slot_end ? r_idx + 2'd1 : r_idx;
  assign w_nib       = 4'(r_disp >> {r_idx, 2'b00});

  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_glyph)
  );

  // Slot timing: divider and digit index advance together at each slot end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_idx <= 2'd0;
    end else begin
      r_div <= w_div_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_GUARD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the an/seg values to register from the current slot phase.
  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = AN_OFF;
    w_seg_nxt   = BLANK;
    case (r_state)
      S_GUARD: begin
        if (w_div_nxt >= DIV_GUARD) w_state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        w_an_nxt  = ~(4'b0001 << r_idx);
        w_seg_nxt = (blank_lz && lz_blank(r_disp, r_idx)) ? BLANK : w_glyph;
        if (w_slot_end) w_state_nxt = S_GUARD;
      end
      default: w_state_nxt = S_GUARD;
    endcase
  end

  // Output registers; frame_done is looked ahead so it lines up with the frame-end cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an         <= AN_OFF;
      r_seg        <= BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= (w_div_nxt == DIV_LAST) && (w_idx_nxt == 2'd3);
    end
  end

  // Word buffering: accept into pend when empty, swap into disp at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp      <= 16'h0000;
      r_pend      <= 16'h0000;
      r_pend_full <= 1'b0;
    end else begin
      if (w_frame_end && r_pend_full) begin
        r_disp      <= r_pend;
        r_pend_full <= 1'b0;
      end
      if (w_xfer) begin
        r_pend      <= in_data;
        r_pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with SCAN_DIV = 8, GUARD = 2.
// Reference model works from the cycle count since reset (slot/position arithmetic).
// Table vectors, hand-written corner sequences, then randomized traffic.
module tb_seg_scan;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        blank_lz;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg_scan #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  logic [7:0] glyph [16];

  // Model state
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_full;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;

  // DUT observations
  logic [7:0]  cap_seg [4];
  logic [3:0]  cap_an  [4];
  logic [15:0] hs_word [$];
  int          hs_time [$];

  typedef struct {
    logic [15:0]      word;
    logic             blank;
    logic [3:0][7:0]  exp_seg;   // [3] = digit 3 ... [0] = digit 0
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h want=%h", name, m_t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_full = 1'b0;
    m_an   = 4'hF;
    m_seg  = 8'hFF;
    hs_word.delete();
    hs_time.delete();
  endtask

  // Hold reset for n edges, check reset outputs, release at a falling edge (cycle 0 begins).
  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0;
    blank_lz = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare against model, advance model across the edge.
  task automatic step(input logic v, input logic [15:0] d, input logic b);
    int         p;
    int         idx;
    logic       fire;
    logic       fd;
    logic [3:0] an_n;
    logic [7:0] seg_n;
    logic [3:0] nib;
    in_valid = v;
    in_data  = d;
    blank_lz = b;
    #1;
    chk("an", an, m_an);
    chk("seg", seg, m_seg);
    chk("frame_done", frame_done, (m_t % FRAME) == FRAME - 1);
    chk("in_ready", in_ready, !m_full);
    if (m_t > 0 && ((m_t - 1) % SD) == SD - 1) begin
      idx = ((m_t - 1) / SD) % 4;
      cap_seg[idx] = seg;
      cap_an[idx]  = an;
    end
    if (v && in_ready) begin
      hs_word.push_back(d);
      hs_time.push_back(m_t);
    end
    fire = v && !m_full;
    fd   = (m_t % FRAME) == FRAME - 1;
    p    = m_t % SD;
    idx  = (m_t / SD) % 4;
    nib  = 4'(m_disp >> (4 * idx));
    if (p < GD) begin
      an_n  = 4'hF;
      seg_n = 8'hFF;
    end else begin
      an_n = ~(4'b0001 << idx);
      if (b && idx > 0 && (m_disp >> (4 * idx)) == 16'h0) seg_n = 8'hFF;
      else seg_n = glyph[nib];
    end
    @(posedge clk);
    m_an  = an_n;
    m_seg = seg_n;
    if (fd && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end
    if (fire) begin
      m_pend = d;
      m_full = 1'b1;
    end
    m_t++;
    @(negedge clk);
  endtask

  task automatic run_to(input int t_end, input logic b);
    while (m_t < t_end) step(1'b0, 16'h0, b);
  endtask

  task automatic chk_frame(input string name, input logic [3:0][7:0] exp);
    logic [3:0] an_exp;
    for (int k = 0; k < 4; k++) begin
      an_exp = ~(4'b0001 << k);
      chk({name, "_seg"}, cap_seg[k], exp[k]);
      chk({name, "_an"}, cap_an[k], an_exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    glyph = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vecs[0] = '{16'h1234, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{16'h0007, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF8}};
    vecs[2] = '{16'h0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{16'h0100, 1'b1, {8'hFF, 8'hF9, 8'hC0, 8'hC0}};
    vecs[4] = '{16'h8F0A, 1'b0, {8'h80, 8'h8E, 8'hC0, 8'h88}};
    vecs[5] = '{16'h0E0B, 1'b1, {8'hFF, 8'h86, 8'hC0, 8'h83}};
    vecs[6] = '{16'h0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[7] = '{16'h5D6C, 1'b0, {8'h92, 8'hA1, 8'h82, 8'hC6}};
    vecs[8] = '{16'h9000, 1'b1, {8'h90, 8'hC0, 8'hC0, 8'hC0}};

    // Reset sequence: three blank cycles, then digit 0 shows "0".
    do_reset(3);
    for (int k = 0; k < 4; k++) begin
      chk("reset_seq_an", an, (k < 3) ? 4'hF : 4'hE);
      chk("reset_seq_seg", seg, (k < 3) ? 8'hFF : 8'hC0);
      step(1'b0, 16'h0, 1'b0);
    end

    // Table vectors: load at cycle 0, swap at 31, capture frame 32..63.
    for (int i = 0; i < 9; i++) begin
      do_reset(2);
      step(1'b1, vecs[i].word, vecs[i].blank);
      run_to(FRAME, vecs[i].blank);
      run_to(2 * FRAME + 1, vecs[i].blank);
      chk_frame("table", vecs[i].exp_seg);
    end

    // Load at cycle 5: busy until the frame_done at 31, shown next frame.
    do_reset(2);
    run_to(5, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    while (m_t < FRAME - 1) begin
      chk("load_busy", in_ready, 1'b0);
      step(1'b0, 16'h0, 1'b0);
    end
    chk("load_fd", frame_done, 1'b1);
    chk("load_busy_fd", in_ready, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    chk("load_ready", in_ready, 1'b1);
    run_to(2 * FRAME + 1, 1'b0);
    chk_frame("load", {8'hF9, 8'hA4, 8'hB0, 8'h99});

    // Back-pressure: AAAA then 5555 held valid; 5555 taken only after the swap.
    do_reset(2);
    step(1'b1, 16'hAAAA, 1'b0);
    while (hs_word.size() < 2 && m_t < 200) step(1'b1, 16'h5555, 1'b0);
    run_to(2 * FRAME + 1, 1'b0);
    chk("bp_count", hs_word.size(), 2);
    if (hs_word.size() >= 2) begin
      chk("bp_word0", hs_word[0], 16'hAAAA);
      chk("bp_word1", hs_word[1], 16'h5555);
      chk("bp_time1", hs_time[1], FRAME);
    end
    chk_frame("bp_first", {8'h88, 8'h88, 8'h88, 8'h88});
    run_to(3 * FRAME + 1, 1'b0);
    chk_frame("bp_second", {8'h92, 8'h92, 8'h92, 8'h92});
    chk("bp_count_final", hs_word.size(), 2);

    // Transfer on the frame_done cycle with an empty buffer: shown one frame later.
    do_reset(2);
    run_to(FRAME - 1, 1'b0);
    chk("simul_fd", frame_done, 1'b1);
    chk("simul_ready", in_ready, 1'b1);
    step(1'b1, 16'h4321, 1'b0);
    chk("simul_busy", in_ready, 1'b0);
    run_to(2 * FRAME + 1, 1'b0);
    chk_frame("simul_old", {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    run_to(3 * FRAME + 1, 1'b0);
    chk_frame("simul_new", {8'h99, 8'hB0, 8'hA4, 8'hF9});

    // Reset at index 2, div 5 with a word pending: the word must be discarded.
    do_reset(2);
    step(1'b1, 16'hBEEF, 1'b0);
    run_to(2 * SD + 5, 1'b0);
    do_reset(1);
    run_to(2 * FRAME + 1, 1'b0);
    chk_frame("midrst", {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    chk("midrst_ready", in_ready, 1'b1);

    // Randomized traffic with occasional resets.
    do_reset(2);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset(1);
      step($urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
